mult_arbiter: RTL and testbench

- Shares one pipelined multiplier between N requesters using round-robin arbitration.
- The multiplier has an input register stage and an output register stage, with no enable and no reset.
- The block accepts one operand pair per cycle, drives registered operands into the multiplier, and tracks each request's ID through a tag pipeline that matches the multiplier latency.
- It returns each product to its requester with a valid pulse.
- Each requester may have at most one operation in flight.

---
 rtl/mult_arbiter_if.sv | 31 +++
 rtl/mult_arbiter.sv | 92 +++++++++
 tb/tb_mult_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// Requester, multiplier and response signals shared between mult_arbiter (slave)
// and the requesters plus external multiplier that surround it (master).
interface mult_arbiter_if #(
   parameter int N     = 4,
   parameter int WIDTH = 32,
   parameter int IDW   = 2
);

   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] a_in;
   logic [N*WIDTH-1:0] b_in;
   logic [N-1:0]       gnt;
   logic [WIDTH-1:0]   mul_a;
   logic [WIDTH-1:0]   mul_b;
   logic [2*WIDTH-1:0] mul_y;
   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic [2*WIDTH-1:0] rsp_y;
   logic               busy;

   modport master (
      output req, a_in, b_in, mul_y,
      input  gnt, mul_a, mul_b, rsp_valid, rsp_id, rsp_y, busy
   );

   modport slave (
      input  req, a_in, b_in, mul_y,
      output gnt, mul_a, mul_b, rsp_valid, rsp_id, rsp_y, busy
   );

endinterface

// File: rtl/mult_arbiter.sv
// Round-robin front end for a shared pipelined multiplier; a tag pipeline carries
// each requester ID alongside its operands so the product can be routed back.
module mult_arbiter #(
   parameter int N       = 4,
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 2,
   parameter int IDW     = 2
) (
   input logic           clk,
   input logic           rst,
   mult_arbiter_if.slave bus
);

   localparam logic [IDW:0] NCOUNT = (IDW+1)'(N);

   logic [IDW-1:0]            ptr;
   logic [N-1:0]              outstanding;
   logic [N-1:0]              eligible;
   logic [N-1:0]              eligRot;
   logic                      found;
   logic [IDW-1:0]            offset;
   logic [IDW:0]              rawSum;
   logic [IDW:0]              idSum;
   logic [IDW:0]              ptrSum;
   logic [IDW-1:0]            grantId;
   logic [IDW-1:0]            ptrNext;
   logic [N-1:0]              grantMask;
   logic [N-1:0]              doneMask;
   logic [WIDTH-1:0]          mulA;
   logic [WIDTH-1:0]          mulB;
   logic [MUL_LAT:0]          tagValid;
   logic [MUL_LAT:0][IDW-1:0] tagId;

   assign eligible = bus.req & ~outstanding;

   // Rotate eligibility so bit 0 is the requester at ptr; the lowest set bit wins.
   always_comb begin
      eligRot = N'({eligible, eligible} >> ptr);
      found   = 1'b0;
      offset  = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (eligRot[j]) begin
            found  = 1'b1;
            offset = IDW'(j);
         end
      end
      rawSum  = {1'b0, ptr} + {1'b0, offset};
      idSum   = (rawSum >= NCOUNT) ? rawSum - NCOUNT : rawSum;
      grantId = idSum[IDW-1:0];
      ptrSum  = idSum + (IDW+1)'(1);
      ptrNext = (ptrSum >= NCOUNT) ? '0 : ptrSum[IDW-1:0];
   end

   // Grant is suppressed during reset so nothing is seen as accepted.
   always_comb begin
      grantMask = '0;
      doneMask  = '0;
      for (int i = 0; i < N; i++) begin
         if (found && !rst && grantId == IDW'(i)) grantMask[i] = 1'b1;
         if (tagValid[MUL_LAT] && tagId[MUL_LAT] == IDW'(i)) doneMask[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= '0;
         outstanding <= '0;
         mulA        <= '0;
         mulB        <= '0;
         tagValid    <= '0;
         tagId       <= '0;
      end else begin
         outstanding <= (outstanding & ~doneMask) | grantMask;
         tagValid    <= {tagValid[MUL_LAT-1:0], found};
         tagId       <= {tagId[MUL_LAT-1:0], grantId};
         if (found) begin
            ptr  <= ptrNext;
            mulA <= bus.a_in[int'(grantId)*WIDTH +: WIDTH];
            mulB <= bus.b_in[int'(grantId)*WIDTH +: WIDTH];
         end
      end
   end

   assign bus.gnt       = grantMask;
   assign bus.mul_a     = mulA;
   assign bus.mul_b     = mulB;
   assign bus.rsp_valid = tagValid[MUL_LAT];
   assign bus.rsp_id    = tagId[MUL_LAT];
   assign bus.rsp_y     = bus.mul_y;
   assign bus.busy      = |outstanding;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: a two-stage multiplier model feeds mul_y and
// a response scoreboard pairs each expected grant with its product and arrival cycle.
module tb_mult_arbiter;

   localparam int N       = 4;
   localparam int WIDTH   = 32;
   localparam int MUL_LAT = 2;
   localparam int IDW     = 2;
   localparam int LAT     = MUL_LAT + 1;

   typedef struct {
      logic [IDW-1:0]     id;
      logic [2*WIDTH-1:0] y;
      int                 due;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   int                 checks = 0;
   int                 failures = 0;
   int                 cyc = 0;
   exp_t               expQ[$];
   exp_t               head;
   logic [WIDTH-1:0]   mra;
   logic [WIDTH-1:0]   mrb;
   logic [2*WIDTH-1:0] mry;

   mult_arbiter_if #(.N(N), .WIDTH(WIDTH), .IDW(IDW)) bus ();

   mult_arbiter #(.N(N), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // External multiplier: input register then output register, no reset.
   always @(posedge clk) begin
      mra <= bus.mul_a;
      mrb <= bus.mul_b;
      mry <= (2*WIDTH)'(mra) * (2*WIDTH)'(mrb);
   end
   assign bus.mul_y = mry;

   // Scoreboard: every response must match the oldest expectation in id, product and cycle.
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL rsp_unexpected cycle=%0d got id=%0d y=%h, required no response",
                     cyc, bus.rsp_id, bus.rsp_y);
         end else begin
            head = expQ.pop_front();
            if (bus.rsp_id !== head.id || bus.rsp_y !== head.y || cyc != head.due) begin
               failures++;
               $display("[TB] FAIL rsp_match got id=%0d y=%h cycle=%0d, required id=%0d y=%h cycle=%0d",
                        bus.rsp_id, bus.rsp_y, cyc, head.id, head.y, head.due);
            end
         end
      end else if (expQ.size() != 0 && cyc > expQ[0].due) begin
         checks++;
         failures++;
         head = expQ.pop_front();
         $display("[TB] FAIL rsp_missing got rsp_valid=%b by cycle=%0d, required id=%0d y=%h at cycle=%0d",
                  bus.rsp_valid, cyc, head.id, head.y, head.due);
      end
   end

   initial begin
      #50000;
      $display("[TB] FAIL watchdog got no finish by time %0t, required completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input logic [N-1:0] reqVal);
      @(posedge clk);
      #1;
      bus.req = reqVal;
   endtask

   task automatic setOperand(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bus.a_in[i*WIDTH +: WIDTH] = a;
      bus.b_in[i*WIDTH +: WIDTH] = b;
   endtask

   task automatic resetDut();
      @(posedge clk);
      #1;
      rst     = 1'b1;
      bus.req = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drainQueue(input string name);
      int waited = 0;
      while (expQ.size() != 0 && waited < 4*LAT + 8) begin
         @(negedge clk);
         #1;
         waited++;
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL drain_%s got pending=%0d, required 0", name, expQ.size());
         expQ.delete();
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL idle_busy_%s got %b, required 0", name, bus.busy);
      end
   endtask

   task automatic test_reset();
      bus.req = '1;
      @(negedge clk);
      checks++;
      if (bus.gnt !== '0) begin failures++; $display("[TB] FAIL reset_gnt got %b, required 0000", bus.gnt); end
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b, required 0", bus.busy); end
      checks++;
      if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b, required 0", bus.rsp_valid); end
      checks++;
      if (bus.rsp_id !== '0) begin failures++; $display("[TB] FAIL reset_rsp_id got %0d, required 0", bus.rsp_id); end
      checks++;
      if (bus.mul_a !== '0 || bus.mul_b !== '0) begin
         failures++;
         $display("[TB] FAIL reset_mul_ops got a=%h b=%h, required 0 0", bus.mul_a, bus.mul_b);
      end
   endtask

   task automatic test_single();
      resetDut();
      setOperand(0, 32'd3, 32'd5);
      applyStimulus(4'b0001);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0001) begin failures++; $display("[TB] FAIL single_gnt got %b, required 0001", bus.gnt); end
      expQ.push_back('{id: IDW'(0), y: (2*WIDTH)'(15), due: cyc + LAT});
      applyStimulus(4'b0000);
      @(negedge clk);
      checks++;
      if (bus.mul_a !== 32'd3 || bus.mul_b !== 32'd5) begin
         failures++;
         $display("[TB] FAIL single_mul_ops got a=%0d b=%0d, required 3 5", bus.mul_a, bus.mul_b);
      end
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got %b, required 1", bus.busy); end
      applyStimulus(4'b0000);
      applyStimulus(4'b0000);
      applyStimulus(4'b0000);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_done got %b, required 0", bus.busy); end
      drainQueue("single");
   endtask

   task automatic test_all_four();
      logic [N-1:0] expGnt;
      resetDut();
      for (int i = 0; i < N; i++) setOperand(i, WIDTH'(i + 1), 32'd10);
      for (int c = 0; c < 2*N; c++) begin
         applyStimulus('1);
         @(negedge clk);
         expGnt = N'(1) << (c % N);
         checks++;
         if (bus.gnt !== expGnt) begin
            failures++;
            $display("[TB] FAIL all_gnt_c%0d got %b, required %b", c, bus.gnt, expGnt);
         end
         expQ.push_back('{id: IDW'(c % N), y: (2*WIDTH)'((c % N + 1) * 10), due: cyc + LAT});
      end
      applyStimulus('0);
      drainQueue("all_four");
   endtask

   task automatic test_outstanding_block();
      logic [N-1:0]       expGnt;
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      a = 32'h0001_2345;
      b = 32'h0000_0777;
      resetDut();
      setOperand(2, a, b);
      for (int c = 0; c <= 2*(MUL_LAT + 2); c++) begin
         applyStimulus(4'b0100);
         @(negedge clk);
         expGnt = (c % (MUL_LAT + 2) == 0) ? 4'b0100 : 4'b0000;
         checks++;
         if (bus.gnt !== expGnt) begin
            failures++;
            $display("[TB] FAIL block_gnt_c%0d got %b, required %b", c, bus.gnt, expGnt);
         end
         if (expGnt != 0) expQ.push_back('{id: IDW'(2), y: (2*WIDTH)'(a) * (2*WIDTH)'(b), due: cyc + LAT});
      end
      applyStimulus('0);
      drainQueue("outstanding");
   endtask

   task automatic test_round_robin();
      logic [N-1:0] reqTab [5];
      logic [N-1:0] gntTab [5];
      int           idTab  [5];
      reqTab = '{4'b0010, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
      gntTab = '{4'b0010, 4'b1000, 4'b0001, 4'b0000, 4'b0010};
      idTab  = '{1, 3, 0, -1, 1};
      resetDut();
      for (int i = 0; i < N; i++) setOperand(i, WIDTH'(100 + i), WIDTH'(200 + i));
      for (int c = 0; c < 5; c++) begin
         applyStimulus(reqTab[c]);
         @(negedge clk);
         checks++;
         if (bus.gnt !== gntTab[c]) begin
            failures++;
            $display("[TB] FAIL rr_gnt_c%0d got %b, required %b", c, bus.gnt, gntTab[c]);
         end
         if (idTab[c] >= 0)
            expQ.push_back('{id: IDW'(idTab[c]),
                             y: (2*WIDTH)'(100 + idTab[c]) * (2*WIDTH)'(200 + idTab[c]),
                             due: cyc + LAT});
      end
      applyStimulus('0);
      drainQueue("round_robin");
   endtask

   task automatic test_width_boundary();
      resetDut();
      setOperand(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      setOperand(3, 32'hFFFF_FFFF, 32'h0000_0001);
      applyStimulus(4'b1001);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0001) begin failures++; $display("[TB] FAIL wide_gnt0 got %b, required 0001", bus.gnt); end
      expQ.push_back('{id: IDW'(0), y: 64'hFFFF_FFFE_0000_0001, due: cyc + LAT});
      applyStimulus(4'b1000);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b1000) begin failures++; $display("[TB] FAIL wide_gnt3 got %b, required 1000", bus.gnt); end
      expQ.push_back('{id: IDW'(3), y: 64'h0000_0000_FFFF_FFFF, due: cyc + LAT});
      applyStimulus('0);
      drainQueue("width");
   endtask

   task automatic test_reset_midflight();
      resetDut();
      setOperand(1, 32'd6, 32'd7);
      applyStimulus(4'b0010);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0010) begin failures++; $display("[TB] FAIL mid_gnt_c0 got %b, required 0010", bus.gnt); end
      for (int c = 1; c <= 2; c++) begin
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(negedge clk);
         checks++;
         if (bus.gnt !== '0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_rst_c%0d got gnt=%b rsp_valid=%b busy=%b, required 0000 0 0",
                     c, bus.gnt, bus.rsp_valid, bus.busy);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0010) begin failures++; $display("[TB] FAIL mid_regrant got %b, required 0010", bus.gnt); end
      expQ.push_back('{id: IDW'(1), y: (2*WIDTH)'(42), due: cyc + LAT});
      for (int c = 4; c <= 5; c++) begin
         applyStimulus(4'b0000);
         @(negedge clk);
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_no_rsp_c%0d got %b, required 0", c, bus.rsp_valid);
         end
      end
      drainQueue("reset_midflight");
   endtask

   initial begin
      rst      = 1'b1;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      test_reset();
      test_single();
      test_all_four();
      test_outstanding_block();
      test_round_robin();
      test_width_boundary();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
